// File: rtl/fibo_pkg.sv
// Shared opcode encodings and controller state type for the Fibonacci sequencer.
// The ALU decodes these same opcode values.
package fibo_pkg;

   localparam logic [2:0] OP_NOP   = 3'b000;
   localparam logic [2:0] OP_ONE   = 3'b001;
   localparam logic [2:0] OP_INC   = 3'b010;
   localparam logic [2:0] OP_DEC   = 3'b011;
   localparam logic [2:0] OP_PASSA = 3'b100;
   localparam logic [2:0] OP_ADD   = 3'b110;
   localparam logic [2:0] OP_PASSB = 3'b111;

   typedef enum logic [2:0] {
      IDLE, LOAD, INIT_A, INIT_B, DEC0, DEC, ADD, DONE
   } state_e;

endpackage

// File: rtl/fibo_controller.sv
// Computes F(n) mod 2^size by issuing one ALU operation per clock and writing
// the result back; the loop ends when the ALU zero flag is seen after a decrement.
//
// state  | meaning
// IDLE   | waiting for start, n latched on accept
// LOAD   | cnt <- n through the ALU; n=0 finishes here
// INIT_A | fa <- 1
// INIT_B | fb <- 1
// DEC0   | first decrement; n=1 finishes here
// DEC    | decrement loop counter, finish on zero
// ADD    | older term <- fa + fb, flip phase
// DONE   | one-cycle done pulse
module fibo_controller
   import fibo_pkg::*;
#(
   parameter int unsigned size = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [size-1:0] n,
   output logic            busy,
   output logic            done,
   output logic [size-1:0] result,
   output logic            overflow,
   output logic [size-1:0] alu_a,
   output logic [size-1:0] alu_b,
   output logic [2:0]      alu_opcode,
   input  logic [size-1:0] alu_d,
   input  logic            alu_zero
);

   state_e          state_q, state_d;
   logic [size-1:0] cnt_q, cnt_d;
   logic [size-1:0] fa_q, fa_d;
   logic [size-1:0] fb_q, fb_d;
   logic [size-1:0] n_q, n_d;
   logic [size-1:0] result_q, result_d;
   logic            phase_q, phase_d;
   logic            ovf_q, ovf_d;
   logic            busy_q, done_q;

   // ALU drive is a pure decode of the current state so the result settles in-cycle
   always_comb begin
      alu_opcode = OP_NOP;
      alu_a      = '0;
      alu_b      = '0;
      case (state_q)
         LOAD: begin
            alu_opcode = OP_PASSA;
            alu_a      = n_q;
         end
         INIT_A, INIT_B: alu_opcode = OP_ONE;
         DEC0, DEC: begin
            alu_opcode = OP_DEC;
            alu_a      = cnt_q;
         end
         ADD: begin
            alu_opcode = OP_ADD;
            alu_a      = fa_q;
            alu_b      = fb_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      fa_d     = fa_q;
      fb_d     = fb_q;
      n_d      = n_q;
      result_d = result_q;
      phase_d  = phase_q;
      ovf_d    = ovf_q;
      case (state_q)
         IDLE: if (start) begin
            n_d     = n;
            ovf_d   = 1'b0;
            phase_d = 1'b0;
            state_d = LOAD;
         end
         LOAD: begin
            cnt_d = alu_d;
            if (alu_zero) begin
               result_d = '0;
               state_d  = DONE;
            end else begin
               state_d = INIT_A;
            end
         end
         INIT_A: begin
            fa_d    = alu_d;
            state_d = INIT_B;
         end
         INIT_B: begin
            fb_d    = alu_d;
            state_d = DEC0;
         end
         DEC0: begin
            cnt_d = alu_d;
            if (alu_zero) begin
               result_d = size'(1);
               state_d  = DONE;
            end else begin
               state_d = DEC;
            end
         end
         DEC: begin
            cnt_d = alu_d;
            if (alu_zero) begin
               result_d = phase_q ? fa_q : fb_q;
               state_d  = DONE;
            end else begin
               state_d = ADD;
            end
         end
         ADD: begin
            if (phase_q) fb_d = alu_d;
            else         fa_d = alu_d;
            phase_d = ~phase_q;
            // a modular sum smaller than an operand means the add wrapped
            if (alu_d < fa_q) ovf_d = 1'b1;
            state_d = DEC;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         fa_q     <= '0;
         fb_q     <= '0;
         n_q      <= '0;
         result_q <= '0;
         phase_q  <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         fa_q     <= fa_d;
         fb_q     <= fb_d;
         n_q      <= n_d;
         result_q <= result_d;
         phase_q  <= phase_d;
         ovf_q    <= ovf_d;
         busy_q   <= (state_d != IDLE) && (state_d != DONE);
         done_q   <= (state_d == DONE);
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign result   = result_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_fibo_controller.sv
// Directed and randomized runs of fibo_controller against a true-integer Fibonacci
// model, with a combinational ALU stand-in driving alu_d/alu_zero.
module tb_fibo_controller;
   import fibo_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] n = '0;
   logic       busy, done, overflow, alu_zero;
   logic [3:0] result, alu_a, alu_b, alu_d;
   logic [2:0] alu_opcode;

   int n_pass  = 0;
   int n_total = 0;

   fibo_controller #(.size(4)) dut (
      .clk(clk), .rst(rst), .start(start), .n(n),
      .busy(busy), .done(done), .result(result), .overflow(overflow),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_d(alu_d), .alu_zero(alu_zero)
   );

   always #5 clk = ~clk;

   always_comb begin
      alu_d = '0;
      case (alu_opcode)
         OP_ONE:   alu_d = 4'd1;
         OP_INC:   alu_d = alu_a + 4'd1;
         OP_DEC:   alu_d = alu_a - 4'd1;
         OP_PASSA: alu_d = alu_a;
         OP_ADD:   alu_d = alu_a + alu_b;
         OP_PASSB: alu_d = alu_b;
         default:  alu_d = '0;
      endcase
   end
   assign alu_zero = (alu_d == 4'd0);

   function automatic int fib(input int k);
      int a = 0;
      int b = 1;
      int t;
      for (int i = 0; i < k; i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   function automatic int busy_len(input int k);
      if (k == 0) return 1;
      if (k == 1) return 4;
      return 2 * k + 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // poke: hold start high with n=5 during the run and through the DONE cycle
   task automatic run(input int nv, input bit poke);
      int  fv, bcnt;
      bit  seen;
      fv = fib(nv);
      @(negedge clk);
      start = 1'b1;
      n     = 4'(nv);
      @(negedge clk);
      start = poke;
      if (poke) n = 4'd5;
      bcnt = 0;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         if (done) seen = 1'b1;
         else begin
            if (busy) bcnt++;
            @(negedge clk);
         end
      end
      chk($sformatf("n%0d_done_seen", nv), 32'(seen), 1);
      chk($sformatf("n%0d_busy_cycles", nv), bcnt, busy_len(nv));
      chk($sformatf("n%0d_result", nv), 32'(result), fv % 16);
      chk($sformatf("n%0d_overflow", nv), 32'(overflow), (fv >= 16) ? 1 : 0);
      chk($sformatf("n%0d_busy_in_done", nv), 32'(busy), 0);
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("n%0d_done_one_cycle", nv), 32'(done), 0);
      if (poke) begin
         chk("poke_no_restart", 32'(busy), 0);
         chk("poke_result_held", 32'(result), fv % 16);
         @(negedge clk);
         chk("poke_still_idle", 32'(busy), 0);
      end
   endtask

   initial begin
      int  cyc;
      int  rn;
      #12;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_result", 32'(result), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_opcode", 32'(alu_opcode), 0);
      chk("rst_alu_a", 32'(alu_a), 0);
      chk("rst_alu_b", 32'(alu_b), 0);
      @(negedge clk);
      rst = 1'b0;

      run(0, 1'b0);
      run(1, 1'b0);
      run(2, 1'b0);
      run(7, 1'b0);
      run(8, 1'b0);
      run(3, 1'b0);
      run(10, 1'b1);

      @(negedge clk);
      start = 1'b1;
      n     = 4'd7;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (alu_opcode !== OP_ADD && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      chk("midrst_reached_add", 32'(alu_opcode), 32'(OP_ADD));
      rst = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_done", 32'(done), 0);
      chk("midrst_result", 32'(result), 0);
      chk("midrst_overflow", 32'(overflow), 0);
      chk("midrst_opcode", 32'(alu_opcode), 0);
      chk("midrst_alu_a", 32'(alu_a), 0);
      @(negedge clk);
      chk("midrst_no_done", 32'(done), 0);
      rst = 1'b0;
      run(6, 1'b0);

      for (int i = 0; i < 10; i++) begin
         rn = int'($urandom_range(0, 15));
         run(rn, 1'b0);
      end
      run(15, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fibo_controller.md
# fibo_controller

Sequencing controller that computes the n-th Fibonacci number by driving the shared combinational ALU one operation per clock. The block owns the loop counter and the two operand registers, issues ALU opcodes and operands, and writes the ALU result back. It watches the ALU zero flag to terminate the loop. It sits between the top-level start/n interface and the ALU instance in `fibo_top`.

## Interface
- `size`, 4, datapath width; must match the ALU `size`.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `n`  in  size  Fibonacci index, unsigned; latched when `start` is accepted.
- `busy`  out  size-independent 1  high in every state except IDLE and DONE.
- `done`  out  1  one-cycle pulse; high exactly while in DONE.
- `result`  out  size  F(n) mod 2^size; holds until the next accepted `start`.
- `overflow`  out  1  sticky per run; set if any addition wrapped.
- `alu_a`, `alu_b`  out  size  ALU operands.
- `alu_opcode`  out  3  ALU opcode.
- `alu_d`  in  size  ALU result, same cycle.
- `alu_zero`  in  1  ALU zero flag, same cycle.

## Operation
- Registers: `cnt`, `fa`, `fb` (size bits each), `n_q`, `phase` (1 bit), `result`, `overflow`, state.
- Convention: F(0)=0, F(1)=F(2)=1. `phase`=0 means `fb` holds the latest term and the next ADD writes `fa`; `phase`=1 is the reverse.
- IDLE: opcode 000; on `start`, `n_q`←`n`, `overflow`←0, `phase`←0, go to LOAD.
- LOAD: opcode 100, `alu_a`=`n_q`, `cnt`←`alu_d`. If `alu_zero`, `result`←0 and go to DONE; otherwise go to INIT_A.
- INIT_A: opcode 001, `fa`←`alu_d` (1). Go to INIT_B.
- INIT_B: opcode 001, `fb`←`alu_d` (1). Go to DEC0.
- DEC0: opcode 011, `alu_a`=`cnt`, `cnt`←`alu_d`. If `alu_zero` (n=1), `result`←1 and go to DONE; otherwise go to DEC.
- DEC: opcode 011, `cnt`←`alu_d`. If `alu_zero`, `result`←(`phase` ? `fa` : `fb`) and go to DONE; otherwise go to ADD.
- ADD: opcode 110, `alu_a`=`fa`, `alu_b`=`fb`. The register selected by `phase` takes `alu_d`. Toggle `phase`. If `alu_d` < `alu_a` (unsigned wrap), set `overflow`. Go to DEC.
- DONE: opcode 000, `done`=1; go to IDLE unconditionally. A `start` in DONE is ignored.
- Arithmetic is modulo 2^size, with no saturation. The `n` range is 0 to 2^size−1.
- Reset values: state=IDLE; `cnt`, `fa`, `fb`, `n_q`, `result` = 0; `phase`, `overflow`, `done`, `busy` = 0; `alu_opcode` = 000; `alu_a`, `alu_b` = 0.
- Unused operand ports drive 0 in each state.

## Timing
- `start` is sampled at edge k; LOAD is active in cycle k+1.
- Busy cycles per n:
  - n=0: 1 busy cycle.
  - n=1: 4 busy cycles.
  - n≥2: 2n+1 busy cycles.
- DONE follows immediately after the last busy cycle.
- `result` and `overflow` are valid from the first DONE cycle onward.
- `start` while busy or in DONE: no effect.
- `rst` mid-run: immediate return to IDLE with reset values. No `done` pulse is produced.
- ALU outputs settle within the same cycle (the ALU is combinational). All register writes occur at the rising edge that ends each state.

## Structure
- Package `fibo_pkg`:
  - Opcode constants: OP_NOP=000, OP_ONE=001, OP_INC=010, OP_DEC=011, OP_PASSA=100, OP_ADD=110, OP_PASSB=111.
  - State enum: IDLE, LOAD, INIT_A, INIT_B, DEC0, DEC, ADD, DONE.
- There is no internal sub-module. `fibo_top` instantiates `fibo_controller` and the ALU with matching `size`.

## Test plan
- n=0, start pulse → 1 busy cycle, done pulse, result=0, overflow=0.
- n=1 → 4 busy cycles, result=1. n=2 → 5 busy cycles, result=1.
- n=7, size=4 → 15 busy cycles, result=13, overflow=0.
- n=8, size=4 → result=5 (21 mod 16), overflow=1. A following run with n=3 → result=2, overflow=0.
- `start` with n=5 asserted mid-run and again in the DONE cycle → ignored; original result is unchanged.
- `rst` asserted in the ADD state of an n=7 run → same-cycle return to IDLE with all outputs 0 and no done pulse. A new start with n=6 → result=8.
